line_buffer_feeder: RTL

Upstream feeder for the 3x3 convolution engine. Accepts a raster-order 8-bit pixel stream and stores it in three rotating line buffers. After each complete row r (r ≥ 2) it streams IMG_W vertical 3-pixel columns (rows r-2, r-1, r) on consecutive cycles with no bubbles, so the engine's internal column shift registers always hold adjacent columns. It also generates the PE enable vector and window-valid and coordinate sideband for the downstream accumulator.

---
 rtl/line_buffer_feeder.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/line_buffer_feeder.sv
// line_buffer_feeder: stores a raster pixel stream in three rotating line buffers and
// replays 3-pixel vertical columns plus window sideband for a 3x3 convolution engine.
module line_buffer_feeder #(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       start,
    input  logic [7:0]                 pix_in,
    input  logic                       pix_valid,
    output logic                       pix_ready,
    output logic [23:0]                col_out,
    output logic                       col_valid,
    output logic                       win_valid,
    output logic [8:0]                 pe_en_ctrl,
    output logic [$clog2(IMG_H)-1:0]   out_row,
    output logic [$clog2(IMG_W)-1:0]   out_col,
    output logic                       busy,
    output logic                       frame_done
);
    localparam int AW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_W + 1);
    localparam int HW = $clog2(IMG_H + 1);
    localparam int OW = $clog2(IMG_H);

    typedef enum logic [1:0] {IDLE, FILL, EMIT, DONE} state_t;

    state_t          state_q, state_d;
    logic [HW-1:0]   row_cnt_q, row_cnt_d;
    logic [AW-1:0]   wr_col_q, wr_col_d;
    logic [RW-1:0]   rd_col_q, rd_col_d;
    logic [1:0]      wb_q, wb_d;
    logic [23:0]     col_out_q, col_out_d;
    logic            col_valid_q, col_valid_d;
    logic            win_valid_q, win_valid_d;
    logic [8:0]      pe_en_q, pe_en_d;
    logic [OW-1:0]   out_row_q, out_row_d;
    logic [AW-1:0]   out_col_q, out_col_d;
    logic [7:0]      mem [3][IMG_W];
    logic            hs, live;
    logic [1:0]      b_top, b_mid, b_bot;
    logic [AW-1:0]   ra;

    assign pix_ready  = state_q == FILL;
    assign busy       = state_q != IDLE;
    assign frame_done = state_q == DONE;
    assign hs         = pix_valid & pix_ready;
    // wb points at the oldest buffer, which is also the next one to be overwritten
    assign b_top      = wb_q;
    assign b_mid      = wb_q == 2'd2 ? 2'd0 : wb_q + 2'd1;
    assign b_bot      = wb_q == 2'd0 ? 2'd2 : wb_q - 2'd1;
    assign ra         = rd_col_q[AW-1:0];
    // EMIT spends one extra drain cycle at rd_col == IMG_W with no live column
    assign live       = state_q == EMIT && rd_col_q < RW'(IMG_W);

    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        wr_col_d  = wr_col_q;
        rd_col_d  = rd_col_q;
        wb_d      = wb_q;
        case (state_q)
            IDLE: if (start) begin
                state_d   = FILL;
                row_cnt_d = '0;
                wr_col_d  = '0;
                wb_d      = 2'd0;
            end
            FILL: if (hs) begin
                if (wr_col_q == AW'(IMG_W - 1)) begin
                    wr_col_d  = '0;
                    wb_d      = wb_q == 2'd2 ? 2'd0 : wb_q + 2'd1;
                    row_cnt_d = row_cnt_q + HW'(1);
                    if (row_cnt_q >= HW'(2)) begin
                        state_d  = EMIT;
                        rd_col_d = '0;
                    end
                end else begin
                    wr_col_d = wr_col_q + AW'(1);
                end
            end
            EMIT: if (rd_col_q == RW'(IMG_W)) begin
                rd_col_d = '0;
                state_d  = row_cnt_q == HW'(IMG_H) ? DONE : FILL;
            end else begin
                rd_col_d = rd_col_q + RW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        col_valid_d = live;
        win_valid_d = live && rd_col_q >= RW'(2);
        pe_en_d     = {9{live}};
        col_out_d   = live ? {mem[b_bot][ra], mem[b_mid][ra], mem[b_top][ra]} : col_out_q;
        out_col_d   = win_valid_d ? AW'(rd_col_q - RW'(2)) : out_col_q;
        out_row_d   = win_valid_d ? OW'(row_cnt_q - HW'(3)) : out_row_q;
    end

    always_ff @(posedge clk) begin
        if (hs) mem[wb_q][wr_col_q] <= pix_in;
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q     <= IDLE;
            row_cnt_q   <= '0;
            wr_col_q    <= '0;
            rd_col_q    <= '0;
            wb_q        <= 2'd0;
            col_out_q   <= '0;
            col_valid_q <= 1'b0;
            win_valid_q <= 1'b0;
            pe_en_q     <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
        end else begin
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            wr_col_q    <= wr_col_d;
            rd_col_q    <= rd_col_d;
            wb_q        <= wb_d;
            col_out_q   <= col_out_d;
            col_valid_q <= col_valid_d;
            win_valid_q <= win_valid_d;
            pe_en_q     <= pe_en_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
        end
    end

    assign col_out    = col_out_q;
    assign col_valid  = col_valid_q;
    assign win_valid  = win_valid_q;
    assign pe_en_ctrl = pe_en_q;
    assign out_row    = out_row_q;
    assign out_col    = out_col_q;
endmodule
